// File: rtl/pipe_fetch_issue_pkg.sv
// rtl/pipe_fetch_issue_pkg.sv - shared instruction format, class/func codes and FSM state for fetch/issue
package pipe_pkg;

  localparam int INSN_W  = 48;
  localparam int FIELD_W = 10;

  // Field bit positions inside the 48-bit instruction word
  localparam int CLS_HI  = 47;
  localparam int CLS_LO  = 44;
  localparam int FUNC_HI = 43;
  localparam int FUNC_LO = 40;
  localparam int RD_HI   = 39;
  localparam int RD_LO   = 30;
  localparam int RS1_HI  = 29;
  localparam int RS1_LO  = 20;
  localparam int RS2_HI  = 19;
  localparam int RS2_LO  = 10;
  localparam int ADDR_HI = 9;
  localparam int ADDR_LO = 0;

  // Instruction classes
  localparam logic [3:0] CLS_ALU  = 4'd0;
  localparam logic [3:0] CLS_NOP  = 4'd1;
  localparam logic [3:0] CLS_JUMP = 4'd2;
  localparam logic [3:0] CLS_HALT = 4'd15;

  // ALU function codes understood by the downstream ALU stage
  localparam logic [3:0] FUNC_ADD  = 4'd0;
  localparam logic [3:0] FUNC_SUB  = 4'd1;
  localparam logic [3:0] FUNC_AND  = 4'd2;
  localparam logic [3:0] FUNC_OR   = 4'd3;
  localparam logic [3:0] FUNC_XOR  = 4'd4;
  localparam logic [3:0] FUNC_SLL  = 4'd5;
  localparam logic [3:0] FUNC_SRL  = 4'd6;
  localparam logic [3:0] FUNC_SRA  = 4'd7;
  localparam logic [3:0] FUNC_SLT  = 4'd8;
  localparam logic [3:0] FUNC_SLTU = 4'd9;
  localparam logic [3:0] FUNC_MUL  = 4'd10;
  localparam logic [3:0] FUNC_PASS = 4'd11;

  // Packed view matching the bit positions above, MSB first
  typedef struct packed {
    logic [3:0]         cls;
    logic [3:0]         func;
    logic [FIELD_W-1:0] rd;
    logic [FIELD_W-1:0] rs1;
    logic [FIELD_W-1:0] rs2;
    logic [FIELD_W-1:0] addr;
  } insn_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  // Undefined classes behave exactly like NOP
  function automatic logic [3:0] norm_cls(input logic [3:0] c);
    case (c)
      CLS_ALU, CLS_JUMP, CLS_HALT: norm_cls = c;
      default:                     norm_cls = CLS_NOP;
    endcase
  endfunction

endpackage

// File: rtl/pipe_fetch_issue_if.sv
// rtl/pipe_fetch_issue_if.sv - issue-side valid/ready handshake and ALU op payload
//   master: drives out_valid, rs1, rs2, rd, func, addr; samples out_ready
//   slave : the downstream ALU stage
interface pipe_fetch_issue_if #(
  parameter int REGW = 10
);
  logic            out_valid;
  logic            out_ready;
  logic [REGW-1:0] rs1;
  logic [REGW-1:0] rs2;
  logic [REGW-1:0] rd;
  logic [3:0]      func;
  logic [REGW-1:0] addr;

  modport master (
    output out_valid, rs1, rs2, rd, func, addr,
    input  out_ready
  );

  modport slave (
    input  out_valid, rs1, rs2, rd, func, addr,
    output out_ready
  );
endinterface

// File: rtl/pipe_fetch_issue_hazard_chk.sv
// rtl/pipe_fetch_issue_hazard_chk.sv - 2-deep rd history and source-operand interlock compare
//   clk1, rst_n        : clock, async active-low reset
//   i_push_valid/i_push_rd : rd of the op loaded this cycle (valid=0 pushes "none")
//   i_rs1/i_rs2        : source indices of the candidate ALU op
//   o_stall            : candidate reads an rd still in flight
module pipe_hazard_chk #(
  parameter int REGW = 10
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            i_push_valid,
  input  logic [REGW-1:0] i_push_rd,
  input  logic [REGW-1:0] i_rs1,
  input  logic [REGW-1:0] i_rs2,
  output logic            o_stall
);
  logic [1:0]      r_hv;
  logic [REGW-1:0] r_hrd [2];

  // History shifts every cycle so an in-flight rd ages out after two slots
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_hv     <= 2'b00;
      r_hrd[0] <= '0;
      r_hrd[1] <= '0;
    end else begin
      r_hv     <= {r_hv[0], i_push_valid};
      r_hrd[1] <= r_hrd[0];
      r_hrd[0] <= i_push_rd;
    end
  end

  always_comb begin
    o_stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (r_hv[i] && ((i_rs1 == r_hrd[i]) || (i_rs2 == r_hrd[i]))) begin
        o_stall = 1'b1;
      end
    end
  end
endmodule

// File: rtl/pipe_fetch_issue.sv
// rtl/pipe_fetch_issue.sv - program memory, PC walk, decode and one-op-per-cycle issue
//   clk1, rst_n      : clock shared with downstream stage 1; async active-low reset
//   prog_we/addr/data: program load port, ignored while RUN
//   start            : 1-cycle pulse, (re)starts execution at PC 0 from IDLE/HALTED
//   iss (master)     : out_valid/out_ready handshake with rs1/rs2/rd/func/addr payload
//   pc, busy, done   : fetch PC, state==RUN, state==HALTED
//   issue_cnt        : saturating count of accepted ops
//   Optional macro PIPE_HAZARD_STALL_EN adds a read-after-write interlock.
module pipe_fetch_issue
  import pipe_pkg::*;
#(
  parameter int PDEPTH = 256,
  parameter int PW     = $clog2(PDEPTH),
  parameter int REGW   = 10
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                prog_we,
  input  logic [PW-1:0]       prog_addr,
  input  logic [INSN_W-1:0]   prog_data,
  input  logic                start,
  pipe_fetch_issue_if.master  iss,
  output logic [PW-1:0]       pc,
  output logic                busy,
  output logic                done,
  output logic [15:0]         issue_cnt
);
  logic [INSN_W-1:0] r_mem [PDEPTH];

  state_t          r_state;
  logic [PW-1:0]   r_pc;
  logic            r_valid;
  logic [REGW-1:0] r_rs1;
  logic [REGW-1:0] r_rs2;
  logic [REGW-1:0] r_rd;
  logic [3:0]      r_func;
  logic [REGW-1:0] r_addr;
  logic [15:0]     r_cnt;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_pc_nxt;
  logic            w_valid_nxt;
  logic            w_load;
  logic            w_decode_en;
  logic [PW-1:0]   w_fetch_pc;
  insn_t           w_insn;
  logic [3:0]      w_cls;
  logic            w_accept;
  logic            w_slot_free;
  logic            w_stall;

  // A start pulse decodes PC 0 in the same cycle, so the first op
  // appears on the outputs right after the start edge.
  assign w_decode_en = (r_state == ST_RUN) || start;
  assign w_fetch_pc  = (r_state == ST_RUN) ? r_pc : '0;
  assign w_insn      = insn_t'(r_mem[w_fetch_pc]);
  assign w_cls       = norm_cls(w_insn.cls);
  assign w_accept    = r_valid && iss.out_ready;
  assign w_slot_free = !r_valid || w_accept;

`ifdef PIPE_HAZARD_STALL_EN
  pipe_hazard_chk #(.REGW(REGW)) u_hazard_chk (
    .clk1         (clk1),
    .rst_n        (rst_n),
    .i_push_valid (w_load),
    .i_push_rd    (w_insn.rd),
    .i_rs1        (w_insn.rs1),
    .i_rs2        (w_insn.rs2),
    .o_stall      (w_stall)
  );
`else
  assign w_stall = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid && !w_accept;
    w_load      = 1'b0;
    if (w_decode_en) begin
      w_state_nxt = ST_RUN;
      w_pc_nxt    = w_fetch_pc;
      if (w_slot_free) begin
        case (w_cls)
          CLS_ALU: begin
            // A stalled op leaves a bubble; pc holds so it is refetched
            if (!w_stall) begin
              w_load      = 1'b1;
              w_valid_nxt = 1'b1;
              w_pc_nxt    = w_fetch_pc + PW'(1);
            end
          end
          CLS_JUMP: w_pc_nxt    = PW'(w_insn.addr);
          CLS_HALT: w_state_nxt = ST_HALTED;
          default:  w_pc_nxt    = w_fetch_pc + PW'(1);
        endcase
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_func  <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      if (w_load) begin
        r_rs1  <= w_insn.rs1;
        r_rs2  <= w_insn.rs2;
        r_rd   <= w_insn.rd;
        r_func <= w_insn.func;
        r_addr <= w_insn.addr;
      end
      if (w_accept && (r_cnt != 16'hFFFF)) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  // Program memory is not reset; writes only while not running
  always_ff @(posedge clk1) begin
    if (prog_we && (r_state != ST_RUN)) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  assign iss.out_valid = r_valid;
  assign iss.rs1       = r_rs1;
  assign iss.rs2       = r_rs2;
  assign iss.rd        = r_rd;
  assign iss.func      = r_func;
  assign iss.addr      = r_addr;
  assign pc            = r_pc;
  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_HALTED);
  assign issue_cnt     = r_cnt;
endmodule

// File: tb/tb_pipe_fetch_issue.sv
// tb/tb_pipe_fetch_issue.sv - self-checking bench for pipe_fetch_issue
module tb_pipe_fetch_issue;
  import pipe_pkg::*;

  localparam int PDEPTH = 256;
  localparam int PW     = 8;
  localparam int REGW   = 10;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              prog_we;
  logic [PW-1:0]     prog_addr;
  logic [47:0]       prog_data;
  logic              start;
  logic [PW-1:0]     pc;
  logic              busy;
  logic              done;
  logic [15:0]       issue_cnt;

  logic              rst4_n;
  logic              we4;
  logic              start4;
  logic [1:0]        pc4;
  logic              busy4;
  logic              done4;
  logic [15:0]       cnt4;

  always #5 clk1 = ~clk1;

  pipe_fetch_issue_if #(.REGW(REGW)) iss ();
  pipe_fetch_issue_if #(.REGW(REGW)) iss4 ();

  pipe_fetch_issue #(.PDEPTH(PDEPTH), .PW(PW), .REGW(REGW)) u_dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .iss       (iss),
    .pc        (pc),
    .busy      (busy),
    .done      (done),
    .issue_cnt (issue_cnt)
  );

  pipe_fetch_issue #(.PDEPTH(4), .PW(2), .REGW(REGW)) u_dut4 (
    .clk1      (clk1),
    .rst_n     (rst4_n),
    .prog_we   (we4),
    .prog_addr (prog_addr[1:0]),
    .prog_data (prog_data),
    .start     (start4),
    .iss       (iss4),
    .pc        (pc4),
    .busy      (busy4),
    .done      (done4),
    .issue_cnt (cnt4)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef logic [43:0] pay_t;
  pay_t sb[$];

  typedef struct {
    logic [3:0] cls;
    logic [3:0] func;
    logic [9:0] rd;
    logic [9:0] rs1;
    logic [9:0] rs2;
    logic [9:0] addr;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [47:0] mk(input logic [3:0] c, input logic [3:0] f, input logic [9:0] rd,
                                     input logic [9:0] rs1, input logic [9:0] rs2, input logic [9:0] ad);
    return {c, f, rd, rs1, rs2, ad};
  endfunction

  function automatic pay_t pay(input logic [3:0] f, input logic [9:0] rd, input logic [9:0] rs1,
                               input logic [9:0] rs2, input logic [9:0] ad);
    return {f, rd, rs1, rs2, ad};
  endfunction

  // Scoreboard: an op visible with out_ready high is accepted at the next edge
  always @(negedge clk1) begin
    if (rst_n && iss.out_valid && iss.out_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got rd %0d with empty scoreboard", iss.rd);
      end else begin
        check("issue_payload", {20'd0, iss.func, iss.rd, iss.rs1, iss.rs2, iss.addr}, {20'd0, sb.pop_front()});
      end
    end
  end

  task automatic cyc();
    @(posedge clk1);
    #1;
  endtask

  task automatic load(input logic [PW-1:0] a, input logic [47:0] w);
    prog_addr = a;
    prog_data = w;
    prog_we   = 1'b1;
    cyc();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    repeat (2) cyc();
    rst_n  = 1'b1;
    rst4_n = 1'b1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      cyc();
      k++;
    end
    check(name, done, 1);
  endtask

  vec_t tbl[9];
  int   n_alu;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst4_n = 1'b0;
    prog_we = 1'b0; we4 = 1'b0; start = 1'b0; start4 = 1'b0;
    prog_addr = '0; prog_data = '0;
    iss.out_ready = 1'b0; iss4.out_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_valid", iss.out_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", issue_cnt, 0);
    check("rst_rd", iss.rd, 0);
    check("rst_func", iss.func, 0);

    // Three ALU ops then HALT
    for (int i = 0; i < 3; i++) begin
      load(PW'(i), mk(CLS_ALU, 4'(i), 10'(5 + i), 10'd0, 10'd0, 10'(i)));
      sb.push_back(pay(4'(i), 10'(5 + i), 10'd0, 10'd0, 10'(i)));
    end
    load(8'd3, mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0));
    iss.out_ready = 1'b1;
    pulse_start();
    @(negedge clk1);
    check("t1_v0", iss.out_valid, 1);
    check("t1_rd0", iss.rd, 5);
    check("t1_busy", busy, 1);
    @(negedge clk1);
    check("t1_rd1", iss.rd, 6);
    @(negedge clk1);
    check("t1_v2", iss.out_valid, 1);
    check("t1_rd2", iss.rd, 7);
    @(negedge clk1);
    check("t1_v3", iss.out_valid, 0);
    check("t1_done", done, 1);
    check("t1_cnt", issue_cnt, 3);
    check("t1_sb", sb.size(), 0);

    // Backpressure mid-stream; a write and a start during RUN are ignored
    do_reset();
    for (int i = 0; i < 6; i++) begin
      load(PW'(i), mk(CLS_ALU, 4'd2, 10'(10 + i), 10'd0, 10'd0, 10'd0));
      sb.push_back(pay(4'd2, 10'(10 + i), 10'd0, 10'd0, 10'd0));
    end
    load(8'd6, mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0));
    iss.out_ready = 1'b1;
    pulse_start();
    cyc();
    iss.out_ready = 1'b0;
    prog_we = 1'b1; prog_addr = 8'd3; prog_data = mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk1);
      check("t2_hold_v", iss.out_valid, 1);
      check("t2_hold_rd", iss.rd, 11);
      check("t2_hold_pc", pc, 2);
      check("t2_hold_cnt", issue_cnt, 1);
      cyc();
      prog_we = 1'b0;
      start = 1'b0;
    end
    iss.out_ready = 1'b1;
    wait_done("t2_done", 40);
    check("t2_cnt", issue_cnt, 6);
    check("t2_sb", sb.size(), 0);

    // JUMP skips pc 3 and resumes at 0x010
    do_reset();
    load(8'd0, mk(CLS_ALU, 4'd0, 10'd1, 10'd0, 10'd0, 10'd0));
    load(8'd1, mk(CLS_ALU, 4'd1, 10'd2, 10'd0, 10'd0, 10'd0));
    load(8'd2, mk(CLS_JUMP, 4'd0, 10'd0, 10'd0, 10'd0, 10'h010));
    load(8'd3, mk(CLS_ALU, 4'd0, 10'd99, 10'd0, 10'd0, 10'd0));
    load(8'h10, mk(CLS_ALU, 4'd3, 10'd4, 10'd0, 10'd0, 10'h2));
    load(8'h11, mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0));
    sb.push_back(pay(4'd0, 10'd1, 10'd0, 10'd0, 10'd0));
    sb.push_back(pay(4'd1, 10'd2, 10'd0, 10'd0, 10'd0));
    sb.push_back(pay(4'd3, 10'd4, 10'd0, 10'd0, 10'h2));
    pulse_start();
    @(negedge clk1);
    @(negedge clk1);
    @(negedge clk1);
    check("t3_bubble_v", iss.out_valid, 0);
    check("t3_jump_pc", pc, 8'h10);
    @(negedge clk1);
    check("t3_tgt_rd", iss.rd, 4);
    wait_done("t3_done", 20);
    check("t3_cnt", issue_cnt, 3);
    check("t3_sb", sb.size(), 0);

    // PC wrap on a 4-word instance
    for (int i = 0; i < 4; i++) begin
      prog_addr = PW'(i);
      prog_data = mk(CLS_ALU, 4'd0, 10'(20 + i), 10'd0, 10'd0, 10'd0);
      we4 = 1'b1;
      cyc();
      we4 = 1'b0;
    end
    iss4.out_ready = 1'b1;
    start4 = 1'b1;
    cyc();
    start4 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk1);
      check("t4_pc", pc4, (k + 1) % 4);
      check("t4_cnt", cnt4, k);
      check("t4_rd", iss4.rd, 20 + (k % 4));
    end

    // Asynchronous reset mid-run; program survives and re-runs
    do_reset();
    for (int i = 0; i < 4; i++) begin
      load(PW'(i), mk(CLS_ALU, 4'd4, 10'(30 + i), 10'd0, 10'd0, 10'd0));
      sb.push_back(pay(4'd4, 10'(30 + i), 10'd0, 10'd0, 10'd0));
    end
    load(8'd4, mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0));
    pulse_start();
    cyc();
    @(negedge clk1);
    check("t5_pre_v", iss.out_valid, 1);
    check("t5_pre_cnt", issue_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_v", iss.out_valid, 0);
    check("t5_async_pc", pc, 0);
    check("t5_async_cnt", issue_cnt, 0);
    check("t5_async_busy", busy, 0);
    sb.delete();
    for (int i = 0; i < 4; i++) sb.push_back(pay(4'd4, 10'(30 + i), 10'd0, 10'd0, 10'd0));
    cyc();
    cyc();
    rst_n = 1'b1;
    pulse_start();
    wait_done("t5_done", 20);
    check("t5_cnt", issue_cnt, 4);
    check("t5_sb", sb.size(), 0);

    // Dependent op: B reads A's rd
    do_reset();
    load(8'd0, mk(CLS_ALU, 4'd1, 10'd3, 10'd1, 10'd2, 10'd0));
    load(8'd1, mk(CLS_ALU, 4'd2, 10'd8, 10'd3, 10'd1, 10'd0));
    load(8'd2, mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0));
    sb.push_back(pay(4'd1, 10'd3, 10'd1, 10'd2, 10'd0));
    sb.push_back(pay(4'd2, 10'd8, 10'd3, 10'd1, 10'd0));
    pulse_start();
    @(negedge clk1);
    check("t6_a_rd", iss.rd, 3);
    @(negedge clk1);
`ifdef PIPE_HAZARD_STALL_EN
    check("t6_bubble1", iss.out_valid, 0);
    @(negedge clk1);
    check("t6_bubble2", iss.out_valid, 0);
    check("t6_stall_pc", pc, 1);
    @(negedge clk1);
`endif
    check("t6_b_v", iss.out_valid, 1);
    check("t6_b_rd", iss.rd, 8);
    wait_done("t6_done", 20);
    check("t6_sb", sb.size(), 0);

    // Table-driven mix of ALU, NOP and undefined classes
    tbl[0] = '{CLS_ALU, FUNC_ADD,  10'd101,  10'd1,  10'd2,  10'h3FF};
    tbl[1] = '{CLS_ALU, FUNC_PASS, 10'd102,  10'd3,  10'd4,  10'h000};
    tbl[2] = '{CLS_NOP, 4'd5,      10'd103,  10'd5,  10'd6,  10'h001};
    tbl[3] = '{CLS_ALU, FUNC_SLL,  10'd1023, 10'h1F, 10'h2A, 10'h155};
    tbl[4] = '{4'd3,    4'd6,      10'd104,  10'd7,  10'd8,  10'h002};
    tbl[5] = '{CLS_ALU, FUNC_SRA,  10'd200,  10'd9,  10'd10, 10'h2AA};
    tbl[6] = '{4'd14,   4'd7,      10'd105,  10'd5,  10'd6,  10'h003};
    tbl[7] = '{CLS_ALU, FUNC_SLTU, 10'd300,  10'd11, 10'd12, 10'h007};
    tbl[8] = '{CLS_ALU, FUNC_MUL,  10'd301,  10'd13, 10'd14, 10'h008};
    do_reset();
    n_alu = 0;
    for (int i = 0; i < 9; i++) begin
      load(PW'(i), mk(tbl[i].cls, tbl[i].func, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].addr));
      if (tbl[i].cls == CLS_ALU) begin
        sb.push_back(pay(tbl[i].func, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].addr));
        n_alu++;
      end
    end
    load(8'd9, mk(CLS_HALT, 4'd0, 10'd0, 10'd0, 10'd0, 10'd0));
    pulse_start();
    wait_done("tbl_done", 40);
    check("tbl_cnt", issue_cnt, n_alu);
    check("tbl_sb", sb.size(), 0);
    check("tbl_halt_pc", pc, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_fetch_issue.md
Name: pipe_fetch_issue

Overview:
- Instruction fetch/decode/issue stage directly upstream of the 4-stage ALU/writeback/memory pipeline.
- Holds a loadable program memory and walks a PC through it.
- Decodes each 48-bit instruction into the pipeline's rs1/rs2/rd/func/addr operand fields and issues one ALU op per cycle under a valid/ready handshake.
- Handles NOP, JUMP and HALT locally; these never reach the pipeline.

Parameters:
- PDEPTH, 256, program memory words (power of 2, ≥2).
- PW, 8, PC width = log2(PDEPTH).
- REGW, 10, register-index/addr field width (matches downstream 1024-entry banks).

Ports:
- clk1  in  1  single clock; downstream stage 1 samples on the same edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe; honoured only in IDLE or HALTED.
- prog_addr  in  PW  program write address.
- prog_data  in  48  instruction word.
- start  in  1  1-cycle pulse; begins execution at PC 0.
- out_ready  in  1  downstream accepts; tied high when driving the pipeline.
- out_valid  out  1  payload holds an ALU op.
- rs1, rs2, rd  out  REGW  operand/destination indices.
- func  out  4  ALU function code (0..11 defined downstream).
- addr  out  REGW  data-memory write address.
- pc  out  PW  current fetch PC.
- busy  out  1  state is RUN.
- done  out  1  state is HALTED.
- issue_cnt  out  16  accepted-op count, saturating at 16'hFFFF.

Behaviour:
- Instruction word fields: [47:44] class (0=ALU, 1=NOP, 2=JUMP, 15=HALT, others treated as NOP); [43:40] func; [39:30] rd; [29:20] rs1; [19:10] rs2; [9:0] addr.
- Program memory has combinational read at pc; writes are synchronous on clk1.
- Reset (async, any state):
  - State IDLE; pc=0.
  - out_valid=0; rs1/rs2/rd/func/addr=0.
  - issue_cnt=0; busy=0; done=0.
  - Program memory contents are not reset.
- FSM:
  - IDLE: start → RUN with pc=0; issue_cnt is not cleared.
  - RUN: per-cycle decode as below.
  - HALTED: start → RUN with pc=0. prog_we allowed.
- RUN, per cycle, when the output register is free (out_valid=0, or out_valid&out_ready this cycle):
  - ALU: load payload from fields; out_valid←1; pc←pc+1.
  - NOP/undefined: out_valid←0; pc←pc+1.
  - JUMP: out_valid←0; pc←addr[PW-1:0].
  - HALT: out_valid←0; pc holds; → HALTED.
- RUN, output register occupied and out_ready=0: payload and out_valid hold stable; pc holds.
- Issue latency: ALU instruction at pc appears on outputs the cycle after fetch. Back-to-back ALU ops issue one per cycle with out_ready=1.
- issue_cnt increments on every out_valid&out_ready cycle.
- pc wraps PDEPTH-1 → 0 on sequential advance.
- A pending valid payload at HALT is still delivered: out_valid stays until accepted, then drops.
- start while RUN is ignored. prog_we while RUN is ignored (no write).
- Simultaneous start and prog_we in IDLE: the write happens and RUN begins; the instruction fetched at pc 0 that cycle is the old contents.

Optional Feature:
- Macro: PIPE_HAZARD_STALL_EN.
- Defined:
  - Keeps a 2-entry history of rd of the last two issue slots. An accepted ALU op pushes its rd; a bubble or held cycle pushes "none".
  - A candidate ALU op whose rs1 or rs2 matches any valid history rd stalls: pc holds, out_valid←0 (bubble), history shifts.
  - Guarantees the operand is read only after downstream regbank writeback.
- Undefined: no interlock. Software must pad with NOPs.

Decomposition:
- Package pipe_pkg:
  - Class codes CLS_ALU/NOP/JUMP/HALT.
  - Field bit positions.
  - Instruction width 48.
  - FSM state enum (IDLE, RUN, HALTED).
  - func code constants 0..11 shared with the ALU stage.
- Sub-module pipe_hazard_chk: history register plus compare; instantiated only under PIPE_HAZARD_STALL_EN.

Test Plan:
- Load 3 ALU ops (rd=5,6,7), then HALT; start; out_ready=1 → out_valid high 3 consecutive cycles starting 1 cycle after start; rd sequence 5,6,7; done=1; issue_cnt=3.
- out_ready=0 for 4 cycles mid-stream → payload and pc frozen; no drop or duplicate; issue_cnt unchanged until release.
- JUMP at pc 2 with addr=0x010; ALU at 0x010 → no issue for the JUMP; next op comes from 0x010.
- PDEPTH=4, no HALT, all ALU → pc sequence 0,1,2,3,0; issue_cnt keeps counting.
- rst_n low mid-RUN with out_valid=1 → out_valid, pc and issue_cnt are 0 immediately (async); prog memory retained; start re-runs the same program.
- With PIPE_HAZARD_STALL_EN: op A rd=3, op B rs1=3 → two bubble cycles between A and B. Without the macro: B issues on the next cycle.
